// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: one block in flight, drives an external round datapath and key store.
// Build macro AES_ROUND_CTRL_PERF_EN adds the blk_count completed-block counter output.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic [127:0] rnd_state,
  output logic         rnd_final,
  input  logic [127:0] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
`ifdef AES_ROUND_CTRL_PERF_EN
  output logic [15:0]  blk_count,
`endif
  output logic         busy
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm;
  logic [127:0] state;
  logic [3:0]   r;

  // r is parked at 0 outside ROUND, so the key index can follow it directly.
  assign rk_idx    = r;
  assign rnd_state = state;
  assign out_block = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state     <= '0;
      r         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rnd_final <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state     <= in_block ^ rk;
            r         <= 4'd1;
            rnd_final <= (NR_L == 4'd1);
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            fsm       <= ROUND;
          end
        end
        ROUND: begin
          state <= rnd_result;
          if (r == NR_L) begin
            r         <= '0;
            rnd_final <= 1'b0;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            r         <= r + 4'd1;
            rnd_final <= ((r + 4'd1) == NR_L);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm       <= IDLE;
          r         <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          rnd_final <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_ROUND_CTRL_PERF_EN
  // Holds its value between handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_count <= '0;
    end else if (out_valid && out_ready) begin
      blk_count <= blk_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench: FIPS-197 vector through an AES-128 model datapath, plus an NR=14 sequencing instance.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  // ---------------- AES model helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y, b, e, s;
    y = 8'h01; b = x; e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) y = gmul(y, b);
      b = gmul(b, b);
    end
    s = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0] t [16];
    logic [7:0] u [16];
    logic [7:0] m [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) t[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        u[rw + 4*c] = t[rw + 4*((c + rw) % 4)];
    for (int c = 0; c < 4; c++) begin
      if (fin) begin
        for (int rw = 0; rw < 4; rw++) m[4*c+rw] = u[4*c+rw];
      end else begin
        m[4*c]   = gmul(u[4*c], 8'h02) ^ gmul(u[4*c+1], 8'h03) ^ u[4*c+2] ^ u[4*c+3];
        m[4*c+1] = u[4*c] ^ gmul(u[4*c+1], 8'h02) ^ gmul(u[4*c+2], 8'h03) ^ u[4*c+3];
        m[4*c+2] = u[4*c] ^ u[4*c+1] ^ gmul(u[4*c+2], 8'h02) ^ gmul(u[4*c+3], 8'h03);
        m[4*c+3] = gmul(u[4*c], 8'h03) ^ u[4*c+1] ^ u[4*c+2] ^ gmul(u[4*c+3], 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] k14(input logic [3:0] i);
    return {8{i, 12'h5a3}};
  endfunction

  logic [127:0] rk_sched [0:10];
  initial begin : key_expand
    logic [31:0]  w [0:43];
    logic [127:0] key;
    logic [31:0]  t;
    logic [7:0]   rc;
    key = KEY;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) rk_sched[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  end

  // ---------------- NR=10 DUT ----------------
  logic         rst_n, in_valid, out_ready;
  logic [127:0] in_block;
  logic         in_ready, rnd_final, out_valid, busy;
  logic [3:0]   rk_idx;
  logic [127:0] rk, rnd_state, rnd_result, out_block;
`ifdef AES_ROUND_CTRL_PERF_EN
  logic [15:0]  blk_count, blk_count14;
`endif

  assign rk         = (rk_idx <= 4'd10) ? rk_sched[rk_idx] : '0;
  assign rnd_result = aes_round(rnd_state, rk, rnd_final);

  aes_round_ctrl #(.NR(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .rk_idx(rk_idx), .rk(rk), .rnd_state(rnd_state), .rnd_final(rnd_final), .rnd_result(rnd_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
`ifdef AES_ROUND_CTRL_PERF_EN
    .blk_count(blk_count),
`endif
    .busy(busy)
  );

  // ---------------- NR=14 DUT ----------------
  logic         in_valid14, out_ready14;
  logic [127:0] in_block14;
  logic         in_ready14, rnd_final14, out_valid14, busy14;
  logic [3:0]   rk_idx14;
  logic [127:0] rk14, rnd_state14, rnd_result14, out_block14;

  assign rk14         = k14(rk_idx14);
  assign rnd_result14 = rnd_state14 ^ rk14 ^ {127'd0, rnd_final14};

  aes_round_ctrl #(.NR(14)) u_dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid14), .in_ready(in_ready14), .in_block(in_block14),
    .rk_idx(rk_idx14), .rk(rk14), .rnd_state(rnd_state14), .rnd_final(rnd_final14), .rnd_result(rnd_result14),
    .out_valid(out_valid14), .out_ready(out_ready14), .out_block(out_block14),
`ifdef AES_ROUND_CTRL_PERF_EN
    .blk_count(blk_count14),
`endif
    .busy(busy14)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one block to the NR=10 DUT, stall the output, then take the result.
  task automatic run_block(input logic [127:0] blk, input logic [127:0] exp, input bit hold,
                           input int stall, output int acc);
    int lat;
    in_valid = 1'b1;
    in_block = blk;
    check_eq("accept_rdy", 128'(in_ready), 128'(1));
    @(negedge clk);
    acc = cyc;
    if (hold) in_block = ~blk;
    else      in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check_eq("round_rdy", 128'(in_ready), 128'(0));
      check_eq("round_busy", 128'(busy), 128'(1));
      check_eq("round_idx", 128'(rk_idx), 128'(lat));
      check_eq("round_final", 128'(rnd_final), 128'(lat == 10));
      if (hold) in_block = {in_block[126:0], in_block[127]};
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 128'(lat), 128'(11));
    check_eq("done_idx", 128'(rk_idx), 128'(0));
    for (int s = 0; s < stall; s++) begin
      check_eq("stall_vld", 128'(out_valid), 128'(1));
      check_eq("stall_blk", out_block, exp);
      check_eq("stall_rdy", 128'(in_ready), 128'(0));
      @(negedge clk);
    end
    check_eq("out_blk", out_block, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("post_vld", 128'(out_valid), 128'(0));
    check_eq("post_rdy", 128'(in_ready), 128'(1));
    check_eq("post_busy", 128'(busy), 128'(0));
  endtask

  initial begin : main
    int acc1, acc2, lat;
    bit seen;
    logic [127:0] e14;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
    in_valid14 = 1'b0; out_ready14 = 1'b0; in_block14 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check_eq("rst_rdy", 128'(in_ready), 128'(1));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_vld", 128'(out_valid), 128'(0));
    check_eq("rst_idx", 128'(rk_idx), 128'(0));
    check_eq("rst_final", 128'(rnd_final), 128'(0));
    check_eq("rst_blk", out_block, 128'(0));
    check_eq("rst_state", rnd_state, 128'(0));
    check_eq("rst_busy14", 128'(busy14), 128'(0));

    // FIPS-197 vector, then a back-to-back block to measure accept spacing.
    run_block(PT, CT, 1'b0, 0, acc1);
    run_block(PT, CT, 1'b0, 0, acc2);
    check_eq("accept_gap", 128'(acc2 - acc1), 128'(12));

    // Output stalled five cycles.
    run_block(PT, CT, 1'b0, 5, acc1);

    // in_valid held with changing data while busy.
    run_block(PT, CT, 1'b1, 2, acc1);

    // Reset wins over a simultaneous input handshake.
    in_valid = 1'b1; in_block = PT; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    check_eq("rstpri_busy", 128'(busy), 128'(0));
    check_eq("rstpri_rdy", 128'(in_ready), 128'(1));

    // Reset in round 5 drops the block.
    in_valid = 1'b1; in_block = PT;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_idx", 128'(rk_idx), 128'(5));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_busy", 128'(busy), 128'(0));
    check_eq("midrst_rdy", 128'(in_ready), 128'(1));
    check_eq("midrst_vld", 128'(out_valid), 128'(0));
    check_eq("midrst_idx", 128'(rk_idx), 128'(0));
    check_eq("midrst_blk", out_block, 128'(0));
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("no_ghost_vld", 128'(seen), 128'(0));
    run_block(PT, CT, 1'b0, 0, acc1);

    // NR=14 sequencing.
    e14 = ~PT ^ k14(4'd0);
    for (int r = 1; r <= 14; r++) e14 = e14 ^ k14(4'(r)) ^ {127'd0, (r == 14)};
    in_valid14 = 1'b1; in_block14 = ~PT;
    check_eq("nr14_idx0", 128'(rk_idx14), 128'(0));
    @(negedge clk);
    in_valid14 = 1'b0;
    lat = 1;
    while (!out_valid14 && lat < 40) begin
      check_eq("nr14_idx", 128'(rk_idx14), 128'(lat));
      check_eq("nr14_final", 128'(rnd_final14), 128'(lat == 14));
      @(negedge clk);
      lat++;
    end
    check_eq("nr14_latency", 128'(lat), 128'(15));
    check_eq("nr14_blk", out_block14, e14);
    check_eq("nr14_final_done", 128'(rnd_final14), 128'(0));
    out_ready14 = 1'b1;
    @(negedge clk);
    out_ready14 = 1'b0;
    check_eq("nr14_post_vld", 128'(out_valid14), 128'(0));

`ifdef AES_ROUND_CTRL_PERF_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("perf_rst", 128'(blk_count), 128'(0));
    run_block(PT, CT, 1'b0, 0, acc1);
    check_eq("perf_one", 128'(blk_count), 128'(1));
    force u_dut.blk_count = 16'hffff;
    @(negedge clk);
    release u_dut.blk_count;
    run_block(PT, CT, 1'b0, 0, acc1);
    run_block(PT, CT, 1'b0, 0, acc1);
    check_eq("perf_wrap", 128'(blk_count), 128'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10: number of AES rounds; legal values 10, 12, 14.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream offers in_block.
REQ-005 SHALL have port in_ready  output  1  controller can accept a block.
REQ-006 SHALL have port in_block  input  128  plaintext; byte 0 at bits 127:120.
REQ-007 SHALL have port rk_idx  output  4  round-key index requested from the external key store.
REQ-008 SHALL have port rk  input  128  round key for rk_idx, combinational, valid in the same cycle.
REQ-009 SHALL have port rnd_state  output  128  state fed to the shared external round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey).
REQ-010 SHALL have port rnd_final  output  1  tells the datapath to skip MixColumns.
REQ-011 SHALL have port rnd_result  input  128  combinational round result for rnd_state/rk.
REQ-012 SHALL have port out_valid  output  1  ciphertext available.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.
REQ-014 SHALL have port out_block  output  128  ciphertext.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM IDLE -> ROUND -> DONE -> IDLE, with a 128-bit state register and a 4-bit round counter r.
REQ-017 In IDLE: in_ready=1, rk_idx=0; on in_valid&&in_ready, state <= in_block ^ rk, r <= 1, go to ROUND.
REQ-018 In ROUND: rk_idx=r, rnd_state=state, rnd_final=(r==NR), state <= rnd_result, r <= r+1.
REQ-019 In ROUND with r==NR: go to DONE next cycle.
REQ-020 In DONE: out_valid=1, out_block=state; out_block SHALL stay stable while out_ready=0; on out_ready go to IDLE.
REQ-021 Latency: block accepted at edge T SHALL produce out_valid=1 in the cycle after edge T+NR (exactly NR+1 cycles), and this SHALL be independent of data.
REQ-022 Throughput: in_ready SHALL be 0 in ROUND and DONE; in_valid in those states SHALL be ignored with no state change. The minimum accept-to-accept interval SHALL be NR+2 cycles.
REQ-023 Outside ROUND: rnd_final=0 and rnd_state=state. Outside IDLE and ROUND: rk_idx=0.
REQ-024 r SHALL never exceed NR; no wrap-around is permitted.

Reset
REQ-025 With rst_n=0 at an edge: FSM=IDLE, r=0, state=0, out_valid=0, busy=0, in_ready=1 in the following cycle.
REQ-026 Reset during ROUND or DONE SHALL discard the in-flight block; no out_valid SHALL appear for it.
REQ-027 Reset SHALL take priority over a simultaneous in or out handshake.

Configuration
REQ-028 Macro AES_ROUND_CTRL_PERF_EN defined: SHALL add output blk_count[15:0], reset to 0, +1 on each out_valid&&out_ready, wrapping 65535 -> 0.
REQ-029 Macro undefined: blk_count port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 NR=10, FIPS-197 App. B: in_block=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, bench supplying key schedule and round datapath -> out_block=3925841d02dc09fbdc118597196a0b32, out_valid 11 cycles after accept.
REQ-031 out_ready=0 for 5 cycles in DONE -> out_valid and out_block held; in_ready=0 throughout; one handshake when out_ready rises.
REQ-032 in_valid held high during ROUND with changing in_block -> result unchanged from REQ-030; second block accepted only after return to IDLE.
REQ-033 rst_n=0 one cycle at round 5 -> busy=0 and in_ready=1 next cycle, no out_valid; next block gives correct ciphertext.
REQ-034 NR=14 -> rk_idx sequence 0,1..14, rnd_final high only at r=14, out_valid 15 cycles after accept.
REQ-035 PERF_EN: 65537 completed blocks (counter forced near wrap) -> blk_count=1.
